// File: rtl/viterbi_codec.sv
// ----------------------------------------------------------------------------
// viterbi_codec
//
// Rate-1/2, constraint-length-3 convolutional encoder (g0=111, g1=101) and a
// hard-decision register-exchange Viterbi decoder. The two datapaths share
// clk/rst but are otherwise independent; the encoder feeds the channel and the
// decoder recovers the bit stream from received symbol pairs.
//
// Parameters
//   TB        survivor (register-exchange) length in bits, >= 8
//   METRIC_W  path-metric width in bits, >= 4
//
// Ports
//   clk           in   1  clock, rising edge
//   rst           in   1  asynchronous reset, active-low
//   enc_enable_i  in   1  encoder input bit valid this cycle
//   enc_d_in      in   1  encoder input bit
//   enc_valid_o   out  1  enc_d_out holds a new symbol
//   enc_d_out     out  2  encoded symbol {g0,g1}
//   dec_enable    in   1  dec_d_in holds a received symbol this cycle
//   dec_d_in      in   2  received hard-decision symbol {g0,g1}
//   dec_d_out     out  1  decoded bit, TB-1 accepted symbols behind the input
// ----------------------------------------------------------------------------
module viterbi_codec #(
  parameter int TB       = 24,
  parameter int METRIC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
  output logic       dec_d_out
);

  // Non-zero start states begin at 16 so the decoder locks onto state 00;
  // a 4-bit metric cannot hold 16, so it starts at its ceiling instead.
  localparam int                  PM_INIT_INT = (METRIC_W > 4) ? 16 : (1 << METRIC_W) - 1;
  localparam logic [METRIC_W-1:0] PM_INIT     = PM_INIT_INT[METRIC_W-1:0];
  localparam logic [METRIC_W-1:0] PM_ZERO     = '0;

  // --------------------------------------------------------------------------
  // Encoder
  // --------------------------------------------------------------------------
  logic [1:0] enc_sr;

  // Shift register holds {older, newer} input bits; the symbol and the
  // register only move when a bit is offered, while valid tracks the enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_sr      <= 2'b00;
      enc_d_out   <= 2'b00;
      enc_valid_o <= 1'b0;
    end else begin
      enc_valid_o <= enc_enable_i;
      if (enc_enable_i) begin
        enc_d_out <= {enc_d_in ^ enc_sr[0] ^ enc_sr[1], enc_d_in ^ enc_sr[1]};
        enc_sr    <= {enc_sr[0], enc_d_in};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Decoder
  // --------------------------------------------------------------------------
  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                  input logic [1:0]          b);
    logic [METRIC_W:0] s;
    s = {1'b0, a} + {{(METRIC_W-1){1'b0}}, b};
    if (s[METRIC_W]) return '1;
    else             return s[METRIC_W-1:0];
  endfunction

  // The oldest survivor bit is consumed on the same edge it would be shifted
  // out, so only TB-1 bits need to be stored per state.
  logic [METRIC_W-1:0] pm       [4];
  logic [TB-2:0]       surv     [4];
  logic [METRIC_W-1:0] acs_pm   [4];
  logic [TB-1:0]       acs_surv [4];
  logic [METRIC_W-1:0] norm_pm  [4];
  logic [METRIC_W-1:0] min_pm;
  logic [1:0]          best;

  // One add-compare-select unit per next state. Predecessors and expected
  // symbols are fixed by the trellis, so they are elaboration-time constants.
  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam logic [1:0] NS  = 2'(g);
    localparam logic [1:0] PS0 = {1'b0, NS[1]};
    localparam logic [1:0] PS1 = {1'b1, NS[1]};
    localparam logic       U   = NS[0];
    localparam logic [1:0] E0  = {U ^ PS0[0] ^ PS0[1], U ^ PS0[1]};
    localparam logic [1:0] E1  = {U ^ PS1[0] ^ PS1[1], U ^ PS1[1]};

    logic [METRIC_W-1:0] cand0;
    logic [METRIC_W-1:0] cand1;
    logic                pick1;
    logic [TB-2:0]       prev_surv;

    assign cand0     = sat_add(pm[PS0], hamming(dec_d_in, E0));
    assign cand1     = sat_add(pm[PS1], hamming(dec_d_in, E1));
    // Strict compare: a tie keeps the predecessor whose older bit is 0.
    assign pick1     = cand1 < cand0;
    assign acs_pm[g] = pick1 ? cand1 : cand0;
    assign prev_surv = pick1 ? surv[PS1] : surv[PS0];
    assign acs_surv[g] = {prev_surv, U};
    assign norm_pm[g]  = acs_pm[g] - min_pm;
  end

  // Smallest new metric and the state holding it; strict compare makes the
  // lowest index win a tie.
  always_comb begin
    min_pm = acs_pm[0];
    best   = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (acs_pm[i] < min_pm) begin
        min_pm = acs_pm[i];
        best   = 2'(i);
      end
    end
  end

  // Metrics are stored normalised so the best path always sits at zero and
  // the registers never creep towards saturation on long streams.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm[0] <= PM_ZERO;
      for (int i = 1; i < 4; i++) pm[i] <= PM_INIT;
      for (int i = 0; i < 4; i++) surv[i] <= '0;
      dec_d_out <= 1'b0;
    end else if (dec_enable) begin
      for (int i = 0; i < 4; i++) begin
        pm[i]   <= norm_pm[i];
        surv[i] <= acs_surv[i][TB-2:0];
      end
      dec_d_out <= acs_surv[best][TB-1];
    end
  end

endmodule

// File: tb/tb_viterbi_codec.sv
// ----------------------------------------------------------------------------
// tb_viterbi_codec
//
// Directed bench for viterbi_codec: reset values, hand-computed encoder
// symbols and ACS metrics, then encoder-to-decoder loopback through a channel
// register with clean data, periodic single-bit errors, enable gaps and an
// inverted-symbol burst. Expected decoder output comes from the transmitted
// bit stream and the count of symbols the decoder has accepted.
// ----------------------------------------------------------------------------
module tb_viterbi_codec;

  localparam int TB       = 24;
  localparam int METRIC_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_enable_i;
  logic       enc_d_in;
  logic       enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable;
  logic [1:0] dec_d_in;
  logic       dec_d_out;

  // Channel: either directly driven symbols or the registered encoder output
  // with an optional error mask applied on the way into the decoder.
  logic       loop_mode;
  logic [1:0] dir_sym;
  logic       dir_en;
  logic [1:0] flip;
  logic [1:0] q_sym;
  logic       q_valid;

  assign dec_d_in   = loop_mode ? (q_sym ^ flip) : dir_sym;
  assign dec_enable = loop_mode ? q_valid : dir_en;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_sym   <= 2'b00;
      q_valid <= 1'b0;
    end else begin
      q_sym   <= enc_d_out;
      q_valid <= enc_valid_o;
    end
  end

  viterbi_codec #(.TB(TB), .METRIC_W(METRIC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_in     (enc_d_in),
    .enc_valid_o  (enc_valid_o),
    .enc_d_out    (enc_d_out),
    .dec_enable   (dec_enable),
    .dec_d_in     (dec_d_in),
    .dec_d_out    (dec_d_out)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc;
  int   enc_idx;
  logic prev_en;
  logic stim [0:1023];

  logic [1:0] enc_exp  [6];
  logic       enc_bits [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pm(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_pm0"}, 32'(dut.pm[0]), a);
    check({tag, "_pm1"}, 32'(dut.pm[1]), b);
    check({tag, "_pm2"}, 32'(dut.pm[2]), c);
    check({tag, "_pm3"}, 32'(dut.pm[3]), d);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst          = 1'b0;
    enc_enable_i = 1'b0;
    enc_d_in     = 1'b0;
    dir_en       = 1'b0;
    dir_sym      = 2'b00;
    flip         = 2'b00;
    #2;
    rst     = 1'b1;
    acc     = 0;
    enc_idx = 0;
    prev_en = 1'b0;
  endtask

  // Loopback run. mode 0 clean, 1 one flipped bit every 16 symbols,
  // 2 ten-cycle enable gaps every 64 bits, 3 four-symbol 11 burst at symbol 40.
  task automatic run_stream(input int n_bits, input int mode, input string tag);
    int                  gap_left;
    int                  next_gap;
    int                  tail;
    int                  budget;
    logic                exp_bit;
    logic                check_now;
    logic [METRIC_W-1:0] mn;
    logic [METRIC_W-1:0] mx;
    gap_left  = 0;
    next_gap  = 32;
    tail      = 0;
    budget    = 0;
    loop_mode = 1'b1;
    while (tail < 4) begin
      @(negedge clk);
      budget++;
      if (budget > 4000) begin
        n_checks++;
        n_fail++;
        $error("[TB] FAIL %s_timeout observed=%0d cycles expected=<4000", tag, budget);
        break;
      end
      if (prev_en) acc++;
      exp_bit   = (acc >= TB) ? stim[acc-TB] : 1'b0;
      check_now = !(mode == 3 && acc > 40 && acc < 44 + 2*TB);
      if (check_now) check(tag, dec_d_out, exp_bit);
      if (mode == 3) begin
        mn = dut.pm[0];
        mx = dut.pm[0];
        for (int i = 1; i < 4; i++) begin
          if (dut.pm[i] < mn) mn = dut.pm[i];
          if (dut.pm[i] > mx) mx = dut.pm[i];
        end
        check({tag, "_pm_min"}, mn, 0);
        check({tag, "_pm_sat"}, (mx == {METRIC_W{1'b1}}), 0);
      end
      prev_en = dec_enable;
      flip    = 2'b00;
      if (dec_enable) begin
        if (mode == 1 && (acc % 16) == 15) flip = ((acc % 32) == 15) ? 2'b10 : 2'b01;
        if (mode == 3 && acc >= 40 && acc < 44) flip = 2'b11;
      end
      if (mode == 2 && enc_idx == next_gap) begin
        gap_left = 10;
        next_gap += 64;
      end
      if (gap_left > 0) begin
        gap_left--;
        enc_enable_i = 1'b0;
      end else if (enc_idx < n_bits) begin
        enc_enable_i = 1'b1;
        enc_d_in     = stim[enc_idx];
        enc_idx++;
      end else begin
        enc_enable_i = 1'b0;
        tail++;
      end
    end
    flip = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    enc_exp  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    enc_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rst          = 1'b0;
    enc_enable_i = 1'b0;
    enc_d_in     = 1'b0;
    loop_mode    = 1'b0;
    dir_en       = 1'b0;
    dir_sym      = 2'b00;
    flip         = 2'b00;
    acc          = 0;
    enc_idx      = 0;
    prev_en      = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Reset state
    check("rst_enc_d_out", enc_d_out, 2'b00);
    check("rst_enc_valid", enc_valid_o, 1'b0);
    check("rst_dec_d_out", dec_d_out, 1'b0);
    check_pm("rst", 0, 16, 16, 16);

    // Hand-computed ACS: symbol 00 then 11, then a disabled cycle holds
    dir_en  = 1'b1;
    dir_sym = 2'b00;
    @(negedge clk);
    check_pm("acs1", 0, 2, 17, 17);
    dir_sym = 2'b11;
    @(negedge clk);
    check_pm("acs2", 2, 0, 3, 3);
    check("acs2_dec_d_out", dec_d_out, 1'b0);
    dir_en  = 1'b0;
    dir_sym = 2'b01;
    @(negedge clk);
    check_pm("acs_hold", 2, 0, 3, 3);

    // Encoder symbols for 1,0,1,1,0,0
    apply_reset();
    check("enc_valid_pre", enc_valid_o, 1'b0);
    for (int i = 0; i < 6; i++) begin
      enc_enable_i = 1'b1;
      enc_d_in     = enc_bits[i];
      @(negedge clk);
      check("enc_sym", enc_d_out, enc_exp[i]);
      check("enc_valid", enc_valid_o, 1'b1);
    end
    enc_enable_i = 1'b0;
    enc_d_in     = 1'b1;
    @(negedge clk);
    check("enc_valid_off", enc_valid_o, 1'b0);
    check("enc_sym_hold", enc_d_out, 2'b11);

    // Mid-stream asynchronous reset after an all-ones run
    for (int i = 0; i < 40; i++) stim[i] = 1'b1;
    apply_reset();
    run_stream(40, 0, "ones");
    enc_enable_i = 1'b1;
    enc_d_in     = 1'b1;
    @(negedge clk);
    check("pre_rst_enc_valid", enc_valid_o, 1'b1);
    check("pre_rst_enc_sym", enc_d_out, 2'b10);
    check("pre_rst_dec_d_out", dec_d_out, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_enc_d_out", enc_d_out, 2'b00);
    check("async_rst_enc_valid", enc_valid_o, 1'b0);
    check("async_rst_dec_d_out", dec_d_out, 1'b0);
    enc_enable_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_pm("after_rst", 0, 16, 16, 16);
    acc     = 0;
    enc_idx = 0;
    prev_en = 1'b0;

    // Random loopback: clean, periodic errors, enable gaps
    for (int i = 0; i < 256; i++) stim[i] = 1'($urandom_range(0, 1));
    apply_reset();
    run_stream(256, 0, "loop_clean");
    apply_reset();
    run_stream(256, 1, "loop_flip");
    apply_reset();
    run_stream(256, 2, "loop_gap");

    // All-zero stream with an inverted burst
    for (int i = 0; i < 160; i++) stim[i] = 1'b0;
    apply_reset();
    run_stream(160, 3, "burst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
